// File: rtl/rx_matched_filt.sv
// rx_matched_filt: symmetric FIR matched filter on the 4x-oversampled receive stream,
// decimated to one sample per symbol and sliced to a 2-bit 4-ASK decision.
module rx_matched_filt #(
    parameter int                NTAPS     = 17,
    parameter int                OSR       = 4,
    parameter int                SYM_PHASE = 0,
    parameter logic signed [17:0] COEF [NTAPS] = '{default: 18'sd0},
    parameter logic signed [17:0] THRESH    = 18'sd65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [17:0] x_in,
    input  logic               x_valid,
    output logic signed [17:0] y,
    output logic               y_valid,
    output logic signed [17:0] y_sym,
    output logic        [1:0]  sym_dec,
    output logic               sym_valid
);
    localparam int NH   = (NTAPS + 1) / 2;
    localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic signed [17:0] r_tap  [NTAPS];
    logic signed [18:0] r_pre  [NH];
    logic signed [36:0] r_prod [NH];
    logic signed [40:0] r_acc;
    logic        [3:0]  r_v;
    logic signed [17:0] r_y;
    logic               r_yv;
    logic [PH_W-1:0]    r_ph;
    logic signed [17:0] r_ysym;
    logic        [1:0]  r_dec;
    logic               r_sv;

    logic signed [40:0] w_sum;
    logic signed [23:0] w_q;
    logic signed [17:0] w_y;
    logic        [1:0]  w_dec;
    logic               w_hit;

    // 41 bits hold NH 37-bit products without wrap for NTAPS up to 33
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NH; k++) w_sum = w_sum + 41'(r_prod[k]);
    end

    assign w_q   = 24'((r_acc + 41'sd65536) >>> 17);
    assign w_y   = (w_q > 24'sd131071) ? 18'sd131071 :
                   (w_q < -24'sd131072) ? -18'sd131072 : w_q[17:0];
    assign w_dec = (r_y < -THRESH) ? 2'b00 : r_y[17] ? 2'b01 : (r_y < THRESH) ? 2'b10 : 2'b11;
    assign w_hit = r_yv && (r_ph == PH_W'(SYM_PHASE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) r_tap[k] <= '0;
            for (int k = 0; k < NH; k++) begin
                r_pre[k]  <= '0;
                r_prod[k] <= '0;
            end
            r_acc  <= '0;
            r_v    <= '0;
            r_y    <= '0;
            r_yv   <= 1'b0;
            r_ph   <= '0;
            r_ysym <= '0;
            r_dec  <= 2'b00;
            r_sv   <= 1'b0;
        end else begin
            if (x_valid) begin
                r_tap[0] <= x_in;
                for (int k = 1; k < NTAPS; k++) r_tap[k] <= r_tap[k-1];
            end
            // centre tap has no mirror partner and is passed through undoubled
            for (int k = 0; k < NH; k++) begin
                r_pre[k]  <= (k == NTAPS - 1 - k) ? 19'(r_tap[k]) :
                             19'(r_tap[k]) + 19'(r_tap[NTAPS-1-k]);
                r_prod[k] <= 37'(r_pre[k]) * 37'(COEF[k]);
            end
            r_acc <= w_sum;
            r_v   <= {r_v[2:0], x_valid};
            r_yv  <= r_v[3];
            if (r_v[3]) r_y <= w_y;
            if (r_yv) r_ph <= (r_ph == PH_W'(OSR - 1)) ? '0 : r_ph + PH_W'(1);
            r_sv <= w_hit;
            if (w_hit) begin
                r_ysym <= r_y;
                r_dec  <= w_dec;
            end
        end
    end

    assign y         = r_y;
    assign y_valid   = r_yv;
    assign y_sym     = r_ysym;
    assign sym_dec   = r_dec;
    assign sym_valid = r_sv;
endmodule

// File: tb/tb_rx_matched_filt.sv
// tb_rx_matched_filt: directed vectors for rx_matched_filt with all-0.5 coefficients,
// OSR=4 and SYM_PHASE=1 (the second filtered output of each symbol is kept).
module tb_rx_matched_filt;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [17:0] x_in = '0;
    logic               x_valid = 1'b0;
    logic signed [17:0] y;
    logic               y_valid;
    logic signed [17:0] y_sym;
    logic        [1:0]  sym_dec;
    logic               sym_valid;

    rx_matched_filt #(
        .NTAPS(17), .OSR(4), .SYM_PHASE(1),
        .COEF('{default: 18'sd65536}), .THRESH(18'sd65536)
    ) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y(y), .y_valid(y_valid), .y_sym(y_sym), .sym_dec(sym_dec), .sym_valid(sym_valid)
    );

    always #5 clk = ~clk;

    int n_edge = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    int checks = 0;
    int failures = 0;
    int ie[$];
    int yq[$];
    int ye[$];
    int sq[$];
    int se[$];
    int dq[$];

    always @(negedge clk) begin
        if (y_valid) begin
            yq.push_back(int'(y));
            ye.push_back(n_edge);
        end
        if (sym_valid) begin
            sq.push_back(int'(y_sym));
            se.push_back(n_edge);
            dq.push_back(int'(sym_dec));
        end
    end

    typedef struct {
        int x;
        int hold;
        int y0;
        int y1;
        int y2;
        int dec;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    task automatic clr();
        ie.delete(); yq.delete(); ye.delete(); sq.delete(); se.delete(); dq.delete();
    endtask

    task automatic drive(input int x, input bit v);
        @(posedge clk);
        #1;
        x_in    = 18'(x);
        x_valid = v;
        if (v) ie.push_back(n_edge + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0);
    endtask

    task automatic do_reset();
        x_valid = 1'b0;
        x_in    = '0;
        reset   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        clr();
    endtask

    initial begin
        tbl[0] = '{65536,   1,  32768,  32768,  32768, 2};
        tbl[1] = '{131071,  30, 65536,  131071, 131071, 3};
        tbl[2] = '{-131072, 30, -65536, -131072, -131072, 0};
        tbl[3] = '{-65537,  2, -32768, -65537, -65537, 0};
        tbl[4] = '{-65536,  2, -32768, -65536, -65536, 1};
        tbl[5] = '{-1,      2,  0,     -1,     -1,     1};
        tbl[6] = '{0,       2,  0,      0,      0,     2};
        tbl[7] = '{65535,   2,  32768,  65535,  65535, 2};
        tbl[8] = '{65536,   2,  32768,  65536,  65536, 3};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_y_sym", int'(y_sym), 0);
        chk("rst_sym_dec", int'(sym_dec), 0);
        chk("rst_sym_valid", int'(sym_valid), 0);

        // table: x held for 'hold' valid samples then zeros; output 1 is the kept symbol
        for (int r = 0; r < 9; r++) begin
            do_reset();
            for (int i = 0; i < 24; i++) drive(i < tbl[r].hold ? tbl[r].x : 0, 1'b1);
            idle(8);
            chk($sformatf("tbl%0d_count", r), yq.size(), 24);
            chk($sformatf("tbl%0d_lat", r), at(ye, 0) - at(ie, 0), 4);
            chk($sformatf("tbl%0d_y0", r), at(yq, 0), tbl[r].y0);
            chk($sformatf("tbl%0d_y1", r), at(yq, 1), tbl[r].y1);
            chk($sformatf("tbl%0d_y2", r), at(yq, 2), tbl[r].y2);
            chk($sformatf("tbl%0d_ysym", r), at(sq, 0), tbl[r].y1);
            chk($sformatf("tbl%0d_dec", r), at(dq, 0), tbl[r].dec);
        end

        // impulse with continuous valid: 17 outputs of 32768 then zeros
        do_reset();
        drive(65536, 1'b1);
        for (int i = 1; i < 24; i++) drive(0, 1'b1);
        idle(8);
        chk("imp_count", yq.size(), 24);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("imp_y%0d", i), at(yq, i), i < 17 ? 32768 : 0);
            chk($sformatf("imp_lat%0d", i), at(ye, i) - at(ie, i), 4);
        end
        chk("imp_nsym", sq.size(), 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("imp_sym%0d", j), at(sq, j), (1 + 4 * j) < 17 ? 32768 : 0);
            chk($sformatf("imp_symedge%0d", j), at(se, j), at(ye, 1 + 4 * j) + 1);
            chk($sformatf("imp_dec%0d", j), at(dq, j), 2);
        end

        // gapped valid 1,0,0,1,1,0: same y sequence, gaps reproduced 4 cycles later
        do_reset();
        begin
            int cnt;
            int pat[6] = '{1, 0, 0, 1, 1, 0};
            cnt = 0;
            for (int i = 0; cnt < 24; i++) begin
                drive((pat[i % 6] == 1 && cnt == 0) ? 65536 : 0, pat[i % 6] == 1);
                cnt += pat[i % 6];
            end
        end
        idle(8);
        chk("gap_count", yq.size(), 24);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("gap_y%0d", i), at(yq, i), i < 17 ? 32768 : 0);
            chk($sformatf("gap_lat%0d", i), at(ye, i) - at(ie, i), 4);
        end
        chk("gap_nsym", sq.size(), 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("gap_symedge%0d", j), at(se, j), at(ye, 1 + 4 * j) + 1);

        // asynchronous reset with samples in flight
        do_reset();
        for (int i = 0; i < 8; i++) drive(65536, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b0);
        chk("mid_y_before", int'(y), 131071);
        chk("mid_ysym_before", int'(y_sym), 65536);
        chk("mid_dec_before", int'(sym_dec), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_y", int'(y), 0);
        chk("mid_y_valid", int'(y_valid), 0);
        chk("mid_y_sym", int'(y_sym), 0);
        chk("mid_sym_dec", int'(sym_dec), 0);
        chk("mid_sym_valid", int'(sym_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        clr();
        idle(10);
        chk("post_no_y", yq.size(), 0);
        chk("post_no_sym", sq.size(), 0);
        for (int i = 0; i < 6; i++) drive(65536, 1'b1);
        idle(8);
        chk("post_count", yq.size(), 6);
        chk("post_y0", at(yq, 0), 32768);
        chk("post_y1", at(yq, 1), 65536);
        chk("post_nsym", sq.size(), 2);
        chk("post_sym0", at(sq, 0), 65536);
        chk("post_symedge0", at(se, 0), at(ye, 1) + 1);
        chk("post_symedge1", at(se, 1), at(ye, 5) + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
